// File: rtl/ttfs_encoder.sv
// ttfs_encoder: time-to-first-spike encoder.
// A start pulse latches one value per neuron. Each neuron then emits a single
// one-cycle spike, delayed by its value in slots after the window opens. A
// full-scale value never matches the slot counter, so that neuron stays silent.
module ttfs_encoder #(
    parameter int DTT_WIDTH = 5,
    parameter int N_NEURONS = 4
) (
    input  logic                 CLK,
    input  logic                 nRES,
    input  logic                 start,
    input  logic [DTT_WIDTH-1:0] input_vectors [N_NEURONS-1:0],
    output logic [N_NEURONS-1:0] spikes,
    output logic                 busy,
    output logic                 finish
);

    // Last slot index is 2^W-2; 2^W-1 is reserved for "no spike".
    localparam logic [DTT_WIDTH-1:0] LAST_T = {{(DTT_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [DTT_WIDTH-1:0] ONE_T  = {{(DTT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [DTT_WIDTH-1:0] r_t, w_t_nxt;
    logic [DTT_WIDTH-1:0] r_val [N_NEURONS-1:0];
    logic                 w_load;
    logic [N_NEURONS-1:0] w_match;
    logic [N_NEURONS-1:0] r_spikes, w_spikes_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_finish, w_finish_nxt;

    // Per-neuron slot compare against the latched value.
    genvar g;
    generate
        for (g = 0; g < N_NEURONS; g++) begin : g_lane
            assign w_match[g] = (r_t == r_val[g]);
        end
    endgenerate

    // Next-state and next-output logic for the window sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_t_nxt      = r_t;
        w_load       = 1'b0;
        w_spikes_nxt = '0;
        w_busy_nxt   = r_busy;
        w_finish_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Sampling start here also covers the cycle after finish:
                // busy simply stays high when a new window is accepted.
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_t_nxt     = '0;
                    w_load      = 1'b1;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b0;
                end
            end
            S_RUN: begin
                w_spikes_nxt = w_match;
                w_busy_nxt   = 1'b1;
                if (r_t == LAST_T) begin
                    // Counter never reaches full scale inside a window.
                    w_state_nxt = S_DONE;
                    w_t_nxt     = '0;
                end else begin
                    w_t_nxt     = r_t + ONE_T;
                end
            end
            S_DONE: begin
                w_finish_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, slot counter and registered outputs.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            r_state  <= S_IDLE;
            r_t      <= '0;
            r_spikes <= '0;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_t      <= w_t_nxt;
            r_spikes <= w_spikes_nxt;
            r_busy   <= w_busy_nxt;
            r_finish <= w_finish_nxt;
        end
    end

    // Per-neuron value latch, loaded only on the accepting edge.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            for (int i = 0; i < N_NEURONS; i++) r_val[i] <= '0;
        end else if (w_load) begin
            for (int i = 0; i < N_NEURONS; i++) r_val[i] <= input_vectors[i];
        end
    end

    assign spikes = r_spikes;
    assign busy   = r_busy;
    assign finish = r_finish;

endmodule

// File: tb/tb_ttfs_encoder.sv
// Directed bench for ttfs_encoder: reset/idle, single and boundary values,
// input latching with ignored starts, back-to-back windows, mid-window reset.
module tb_ttfs_encoder;

    logic       CLK = 1'b0;
    logic       nRES;
    logic       start;
    logic [4:0] iv [3:0];
    logic [3:0] spikes;
    logic       busy;
    logic       finish;

    int n_tests = 0;
    int n_fail  = 0;

    ttfs_encoder #(.DTT_WIDTH(5), .N_NEURONS(4)) dut (
        .CLK(CLK), .nRES(nRES), .start(start), .input_vectors(iv),
        .spikes(spikes), .busy(busy), .finish(finish)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " spk"}, {28'd0, spikes}, 32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " fin"}, {31'd0, finish}, 32'd0);
    endtask

    // Open a window with values v (v[3] is neuron 3) and check every cycle
    // up to last_k cycles after the accepting edge. hold keeps start high.
    // poke changes the inputs after E0 and fires starts at E0+10 and E0+32.
    task automatic do_window(input string name, input logic [3:0][4:0] v,
                             input bit hold, input int last_k, input bit poke);
        logic [3:0] exp_spk;
        logic       exp_busy;
        for (int i = 0; i < 4; i++) iv[i] = v[i];
        start = 1'b1;
        tick();
        start = hold;
        chk($sformatf("%s k=0 busy", name), {31'd0, busy}, 32'd1);
        chk($sformatf("%s k=0 spk", name), {28'd0, spikes}, 32'd0);
        chk($sformatf("%s k=0 fin", name), {31'd0, finish}, 32'd0);
        for (int k = 1; k <= last_k; k++) begin
            tick();
            for (int i = 0; i < 4; i++)
                exp_spk[i] = (v[i] != 5'd31) && (k == int'(v[i]) + 1);
            exp_busy = (k <= 32) ? 1'b1 : hold;
            chk($sformatf("%s k=%0d spk", name, k), {28'd0, spikes}, {28'd0, exp_spk});
            chk($sformatf("%s k=%0d busy", name, k), {31'd0, busy}, {31'd0, exp_busy});
            chk($sformatf("%s k=%0d fin", name, k), {31'd0, finish}, {31'd0, (k == 32)});
            if (poke) begin
                if (k == 1) for (int i = 0; i < 4; i++) iv[i] = 5'd2;
                if (k == 9 || k == 31) start = 1'b1;
                if (k == 10 || k == 32) start = 1'b0;
            end
        end
    endtask

    initial begin
        nRES  = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) iv[i] = 5'd0;

        // Reset held for three cycles, then idle with start low.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_quiet($sformatf("rst c=%0d", c));
        end
        nRES = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            chk_quiet($sformatf("idle c=%0d", c));
        end

        // Single neuron, then boundary values.
        do_window("single", {5'd31, 5'd31, 5'd31, 5'd4}, 1'b0, 33, 1'b0);
        tick();
        do_window("bound", {5'd0, 5'd30, 5'd31, 5'd15}, 1'b0, 33, 1'b0);
        tick();

        // Shared value, inputs changed after E0, starts during the window ignored.
        do_window("latch", {5'd7, 5'd7, 5'd7, 5'd7}, 1'b0, 33, 1'b1);
        tick();
        chk_quiet("latch post");

        // Back-to-back windows with start held high.
        do_window("b2b0", {5'd1, 5'd2, 5'd3, 5'd4}, 1'b1, 32, 1'b0);
        do_window("b2b1", {5'd1, 5'd2, 5'd3, 5'd4}, 1'b0, 33, 1'b0);
        tick();

        // Reset in the middle of a window.
        for (int i = 0; i < 4; i++) iv[i] = 5'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        chk("mid busy pre", {31'd0, busy}, 32'd1);
        nRES = 1'b0;
        #1;
        chk_quiet("mid rst now");
        tick();
        chk_quiet("mid rst k=11");
        tick();
        chk_quiet("mid rst k=12");
        nRES = 1'b1;
        for (int k = 13; k <= 24; k++) begin
            tick();
            chk_quiet($sformatf("mid post k=%0d", k));
        end
        do_window("after", {5'd20, 5'd20, 5'd20, 5'd20}, 1'b0, 33, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
